ai_shot_sequencer: RTL

// Bus master that drives the BattleChip AI density accelerator's 16-word slave port for one shot request.

---
 rtl/ai_shot_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/ai_shot_sequencer.sv
// ai_shot_sequencer
// Bus master for the AI density accelerator's 16-word slave port. It serves one
// shot request at a time. It takes a board snapshot, writes the fired words, the
// hits words and the ships word into the accelerator, then issues the start
// command. It waits for the compute to begin and then to end, reads back the
// chosen cell index, and returns that index to the requester.
//
// Ports
//   clock, reset_n          system clock, synchronous active-low reset
//   cmd_valid/cmd_ready     snapshot handshake (cmd_fired, cmd_hits, cmd_ships)
//   res_valid/res_ready     result handshake (res_index, res_error)
//   busy                    high from snapshot accept until the result is consumed
//   ai_addr, ai_write_en, ai_read_en, ai_wdata   registered accelerator bus outputs
//   ai_rdata, ai_wait       accelerator read data and wait_request
//
// state | meaning
// IDLE  | ready for a snapshot
// WRITE | writing snapshot words 1..9
// START | writing the start command to word 0
// ARM   | waiting for ai_wait to rise (compute has begun)
// BUSY  | waiting for ai_wait to fall (compute finished)
// READ  | single read of word 0
// DONE  | result presented until consumed
module ai_shot_sequencer #(
    parameter int TIMEOUT = 2048,
    parameter int CNT_W   = 12
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [99:0]  cmd_fired,
    input  logic [99:0]  cmd_hits,
    input  logic [4:0]   cmd_ships,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [6:0]   res_index,
    output logic         res_error,
    output logic         busy,
    output logic [3:0]   ai_addr,
    output logic         ai_write_en,
    output logic         ai_read_en,
    output logic [31:0]  ai_wdata,
    input  logic [31:0]  ai_rdata,
    input  logic         ai_wait
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        START,
        ARM,
        BUSY,
        READ,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state;
    logic [3:0]         word;
    logic [99:0]        fired_q;
    logic [99:0]        hits_q;
    logic [4:0]         ships_q;
    logic [CNT_W-1:0]   cnt;

    function automatic logic [31:0] word_data(input logic [3:0]  w,
                                              input logic [99:0] f,
                                              input logic [99:0] h,
                                              input logic [4:0]  s);
        logic [31:0] d;
        d = 32'd0;
        case (w)
            4'd1: d = f[31:0];
            4'd2: d = f[63:32];
            4'd3: d = f[95:64];
            4'd4: d = {28'd0, f[99:96]};
            4'd5: d = h[31:0];
            4'd6: d = h[63:32];
            4'd7: d = h[95:64];
            4'd8: d = {28'd0, h[99:96]};
            4'd9: d = {27'd0, s};
            default: d = 32'd0;
        endcase
        return d;
    endfunction

    // The counter saturates instead of wrapping; the wait states leave on the
    // cycle that brings it to TIMEOUT.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c);
        return (c == TMO) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            word        <= 4'd0;
            fired_q     <= '0;
            hits_q      <= '0;
            ships_q     <= '0;
            cnt         <= '0;
            cmd_ready   <= 1'b1;
            res_valid   <= 1'b0;
            res_index   <= 7'd0;
            res_error   <= 1'b0;
            busy        <= 1'b0;
            ai_addr     <= 4'd0;
            ai_write_en <= 1'b0;
            ai_read_en  <= 1'b0;
            ai_wdata    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        fired_q     <= cmd_fired;
                        hits_q      <= cmd_hits;
                        ships_q     <= cmd_ships;
                        word        <= 4'd1;
                        ai_addr     <= 4'd1;
                        ai_write_en <= 1'b1;
                        // Latched copies are not visible yet, so word 1 comes from the inputs.
                        ai_wdata    <= word_data(4'd1, cmd_fired, cmd_hits, cmd_ships);
                        cmd_ready   <= 1'b0;
                        busy        <= 1'b1;
                        state       <= WRITE;
                    end
                end
                WRITE: begin
                    if (!ai_wait) begin
                        if (word == 4'd9) begin
                            ai_addr  <= 4'd0;
                            ai_wdata <= 32'd0;
                            state    <= START;
                        end else begin
                            word     <= word + 4'd1;
                            ai_addr  <= word + 4'd1;
                            ai_wdata <= word_data(word + 4'd1, fired_q, hits_q, ships_q);
                        end
                    end
                end
                START: begin
                    if (!ai_wait) begin
                        ai_write_en <= 1'b0;
                        cnt         <= '0;
                        state       <= ARM;
                    end
                end
                ARM: begin
                    if (ai_wait) begin
                        cnt   <= '0;
                        state <= BUSY;
                    end else begin
                        cnt <= cnt_next(cnt);
                        if (cnt == TMO_LAST || cnt == TMO) begin
                            res_error <= 1'b1;
                            res_index <= 7'd0;
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                BUSY: begin
                    if (!ai_wait) begin
                        ai_addr    <= 4'd0;
                        ai_read_en <= 1'b1;
                        state      <= READ;
                    end else begin
                        cnt <= cnt_next(cnt);
                        if (cnt == TMO_LAST || cnt == TMO) begin
                            res_error <= 1'b1;
                            res_index <= 7'd0;
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                READ: begin
                    ai_read_en <= 1'b0;
                    if (ai_rdata[31:7] != 25'd0 || ai_rdata[6:0] > 7'd99) begin
                        res_error <= 1'b1;
                        res_index <= 7'd0;
                    end else begin
                        res_error <= 1'b0;
                        res_index <= ai_rdata[6:0];
                    end
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
